csa_word_sequencer: RTL and testbench
=====================================

Name: csa_word_sequencer

Overview:
- Multi-cycle, word-width add/subtract controller built around one 4-bit carry-select adder slice.
- Each operation is split into nibbles and processed LSB-first, one nibble per clock; the carry is held in a register between nibbles.
- Used wherever a wide add is needed but one narrow adder is cheaper than a full-width one.
- Valid/ready handshake on both the request side and the result side.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..16.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  request present
in_ready  output  1  block can accept a request
a  input  W  operand A
b  input  W  operand B
sub  input  1  0 = A+B, 1 = A-B
out_valid  output  1  result present
out_ready  input  1  consumer accepts the result
sum  output  W  result
cout  output  1  add: carry out; sub: 1 = no borrow (A >= B unsigned)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; operand registers, idx, carry register, sum, cout, ovf and out_valid all cleared to 0.
  - in_ready = 0 while rst is high and 1 after release, since in_ready = (state==IDLE) & ~rst.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - A request is accepted on the edge where in_valid & in_ready.
  - On acceptance, latch a_r = a, b_r = sub ? ~b : b, carry = sub, sub_r = sub; set idx = 0; go to RUN.
  - in_valid while not in IDLE is ignored and is not queued.
- RUN (in_ready = 0, out_valid = 0):
  - The slice adds a_r[4*idx+:4] + b_r[4*idx+:4] with carry-in = carry.
  - On each edge, sum[4*idx+:4] takes the slice sum, carry takes the slice carry-out, and idx increments.
  - At idx == NIBBLES-1:
    - cout = slice carry-out.
    - ovf = (a_r[W-1] ~^ b_r[W-1]) & (a_r[W-1] ^ slice_sum[3]).
    - out_valid = 1; go to DONE.
- Latency: out_valid rises exactly NIBBLES edges after the accept edge. Throughput is one operation per NIBBLES+2 cycles at best.
- DONE:
  - out_valid = 1; sum, cout and ovf are held stable for as long as out_ready = 0.
  - On an edge with out_ready = 1, out_valid is cleared and the block returns to IDLE. in_ready rises the following cycle, with no same-cycle turnaround.
- Input changes on a, b or sub after acceptance have no effect on the result in flight.
- sum, cout and ovf are only defined while out_valid = 1. During RUN, sum is partially overwritten nibble by nibble.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately: outputs go to reset values and no out_valid is produced. The next request after reset release behaves normally.
- Width rules:
  - All arithmetic is modulo 2^W, with no saturation.
  - idx is $clog2(NIBBLES) bits and never wraps, because the transition to DONE occurs at NIBBLES-1.
- No combinational path from inputs to outputs, other than rst to in_ready.

Test Plan (NIBBLES=4):
1. Basic add: a=0x1234, b=0x1111, sub=0, single accept → out_valid exactly 4 edges later; sum=0x2345, cout=0, ovf=0; in_ready=0 throughout RUN/DONE.
2. Full carry ripple:
   - 0xFFFF+0x0001 → sum=0x0000, cout=1, ovf=0.
   - 0x7FFF+0x0001 → sum=0x8000, cout=0, ovf=1.
3. Subtract:
   - 0x0005-0x0007 → sum=0xFFFE, cout=0, ovf=0.
   - 0x8000-0x0001 → sum=0x7FFF, cout=1, ovf=1.
   - 0x1234-0x1234 → sum=0x0000, cout=1, ovf=0.
4. Backpressure:
   - Hold out_ready=0 for 10 cycles after out_valid → sum, cout, ovf and out_valid stay stable; in_valid pulses with other operands during that window are ignored.
   - Raise out_ready → out_valid drops after that edge; in_ready=1 on the next cycle.
5. Operand stability: change a, b and sub every cycle during RUN → result equals the operation captured at the accept edge.
6. Reset mid-operation:
   - Assert rst asynchronously 2 edges into RUN of 0xFFFF+0x0001 → sum, cout, ovf and out_valid go to 0 immediately; no out_valid after release.
   - A following 0x00FF+0x0001 → sum=0x0100, cout=0.

Source files
------------

// File: rtl/csa_word_sequencer_if.sv
// rtl/csa_word_sequencer_if.sv - request/result handshake bundle for csa_word_sequencer
interface csa_word_sequencer_if #(
  parameter int NIBBLES = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [4*NIBBLES-1:0]   a;
  logic [4*NIBBLES-1:0]   b;
  logic                   sub;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*NIBBLES-1:0]   sum;
  logic                   cout;
  logic                   ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/csa_word_sequencer.sv
// rtl/csa_word_sequencer.sv - word add/sub built from one 4-bit carry-select slice, one nibble per clock
module csa_word_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  csa_word_sequencer_if.slave  bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [W-1:0]    a_r, b_r, sum_r;
  logic [IW-1:0]   idx;
  logic            carry, cout_r, ovf_r;
  logic            last;
  logic [3:0]      an, bn, slice_sum;
  logic [4:0]      sel0, sel1;
  logic            slice_co;

  // Both carry-in outcomes are precomputed; the held carry only picks one.
  assign an   = a_r[idx*4 +: 4];
  assign bn   = b_r[idx*4 +: 4];
  assign sel0 = {1'b0, an} + {1'b0, bn};
  assign sel1 = {1'b0, an} + {1'b0, bn} + 5'd1;
  assign {slice_co, slice_sum} = carry ? sel1 : sel0;
  assign last = (idx == IW'(NIBBLES - 1));

  assign bus.in_ready  = (state == IDLE) & ~rst;
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = RUN;
      RUN:     if (last)         state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            // Subtraction is A + ~B + 1: the +1 enters as the first carry-in.
            a_r   <= bus.a;
            b_r   <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_r[idx*4 +: 4] <= slice_sum;
          carry             <= slice_co;
          if (last) begin
            cout_r <= slice_co;
            ovf_r  <= (a_r[W-1] ~^ b_r[W-1]) & (a_r[W-1] ^ slice_sum[3]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_word_sequencer.sv
// tb/tb_csa_word_sequencer.sv - vector table, random ops vs arithmetic model, backpressure and reset abort
module tb_csa_word_sequencer;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  csa_word_sequencer_if #(.NIBBLES(NIBBLES)) bus ();

  csa_word_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    int           hold;
    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Reference: plain wide arithmetic, borrow as an unsigned compare.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    res_t r;
    logic [W:0] full;
    if (!s) begin
      full = {1'b0, x} + {1'b0, y};
      r.s  = full[W-1:0];
      r.c  = full[W];
      r.o  = (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
    end else begin
      r.s = x - y;
      r.c = (x >= y);
      r.o = (x[W-1] != y[W-1]) && (r.s[W-1] != x[W-1]);
    end
    return r;
  endfunction

  task automatic scramble();
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.sub      = 1'($urandom);
    bus.in_valid = 1'($urandom);
  endtask

  task automatic do_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic ts, input int hold,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    int waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({nm, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);
    bus.a = ta; bus.b = tb; bus.sub = ts; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    scramble();
    for (int k = 1; k <= NIBBLES; k++) begin
      @(posedge clk);
      @(negedge clk);
      check({nm, " out_valid timing"}, 32'(bus.out_valid), 32'(k == NIBBLES));
      check({nm, " in_ready busy"}, 32'(bus.in_ready), 32'd0);
      scramble();
    end
    check({nm, " sum"},  32'(bus.sum),  32'(es));
    check({nm, " cout"}, 32'(bus.cout), 32'(ec));
    check({nm, " ovf"},  32'(bus.ovf),  32'(eo));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check({nm, " held out_valid"}, 32'(bus.out_valid), 32'd1);
      check({nm, " held result"}, {15'd0, bus.cout, bus.ovf, bus.sum}, {15'd0, ec, eo, es});
      scramble();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({nm, " out_valid after take"}, 32'(bus.out_valid), 32'd0);
    check({nm, " in_ready after take"},  32'(bus.in_ready),  32'd1);
  endtask

  vec_t vecs[$];
  res_t r;
  logic [W-1:0] ra, rb;
  logic         rs;

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.sub = 1'b0;

    vecs.push_back('{16'h1234, 16'h1111, 1'b0, 0,  16'h2345, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1,  16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 0,  16'h8000, 1'b0, 1'b1});
    vecs.push_back('{16'h0005, 16'h0007, 1'b1, 2,  16'hFFFE, 1'b0, 1'b0});
    vecs.push_back('{16'h8000, 16'h0001, 1'b1, 0,  16'h7FFF, 1'b1, 1'b1});
    vecs.push_back('{16'h1234, 16'h1234, 1'b1, 0,  16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'hA5C3, 16'h5A3C, 1'b0, 10, 16'hFFFF, 1'b0, 1'b0});

    #2;
    check("reset in_ready", 32'(bus.in_ready), 32'd0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset result", {15'd0, bus.cout, bus.ovf, bus.sum}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready after release", 32'(bus.in_ready), 32'd1);

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].hold,
            vecs[i].e_sum, vecs[i].e_cout, vecs[i].e_ovf);

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = (n % 5 == 0) ? ra : W'($urandom);
      rs = 1'($urandom);
      r  = model(ra, rb, rs);
      do_op($sformatf("rand%0d", n), ra, rb, rs, int'($urandom_range(0, 3)), r.s, r.c, r.o);
    end

    // Abort two edges into RUN.
    @(negedge clk);
    bus.a = 16'hFFFF; bus.b = 16'h0001; bus.sub = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort out_valid", 32'(bus.out_valid), 32'd0);
    check("abort result", {15'd0, bus.cout, bus.ovf, bus.sum}, 32'd0);
    check("abort in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NIBBLES + 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("no out_valid after abort", 32'(bus.out_valid), 32'd0);
      check("idle after abort", 32'(bus.in_ready), 32'd1);
    end
    do_op("post-reset", 16'h00FF, 16'h0001, 1'b0, 0, 16'h0100, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
